// File: rtl/pipe_exe_mdu.sv
// Iterative 32x32 multiply / divide unit for the execute stage.
// Owns HI/LO and stalls the front of the pipeline while an operation iterates.
module pipe_exe_mdu (
  input  logic        clock,
  input  logic        reset,
  input  logic        estart,
  input  logic [1:0]  eop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        emthi,
  input  logic        emtlo,
  input  logic        eflush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_div, sa, sb;
  logic [31:0] opa, opb;
  logic [63:0] acc, acc_step;
  logic [4:0]  count;

  logic        start, div0, sa_in, sb_in;
  logic [31:0] abs_a, abs_b;
  logic [32:0] sum, rem_sh, diff;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  assign start = (state == IDLE) && estart && !eflush;
  assign div0  = start && eop[1] && (eb == 32'd0);
  assign sa_in = ~eop[0] & ea[31];
  assign sb_in = ~eop[0] & eb[31];
  assign abs_a = sa_in ? -ea : ea;
  assign abs_b = sb_in ? -eb : eb;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div0 ? DONE : RUN;
      RUN:     if (eflush) state_nxt = IDLE;
               else if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: stall decodes the inputs combinationally so the upstream registers freeze in the start cycle itself.
  always_comb begin
    stall = start || (state == RUN);
    busy  = (state != IDLE);
    done  = (state == DONE);
  end

  // One iteration: shift-add (multiplier LSB first) or restoring shift-subtract (dividend MSB first).
  always_comb begin
    sum    = {1'b0, acc[63:32]} + {1'b0, (opb[0] ? opa : 32'd0)};
    rem_sh = {acc[63:32], opa[31]};
    diff   = rem_sh - {1'b0, opb};
    if (is_div) begin
      if (rem_sh >= {1'b0, opb}) acc_step = {diff[31:0], acc[30:0], 1'b1};
      else                       acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
    end else begin
      acc_step = {sum, acc[31:1]};
    end
  end

  // Sign correction applied to the final iteration's value.
  always_comb begin
    prod = (sa ^ sb) ? -acc_step : acc_step;
    if (is_div) begin
      res_lo = (sa ^ sb) ? -acc_step[31:0]  : acc_step[31:0];
      res_hi = sa        ? -acc_step[63:32] : acc_step[63:32];
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // NOTE: every datapath register has a defined reset value, since an aborted operation must leave nothing stale.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      acc    <= 64'd0;
      count  <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= eop[1];
            sa     <= sa_in;
            sb     <= sb_in;
            opa    <= abs_a;
            opb    <= abs_b;
            acc    <= 64'd0;
            count  <= 5'd0;
            if (div0) begin
              hi <= ea;
              lo <= 32'hFFFF_FFFF;
            end
          end else if (!estart && !eflush) begin
            if (emthi) hi <= ea;
            if (emtlo) lo <= ea;
          end
        end
        RUN: begin
          if (!eflush) begin
            acc   <= acc_step;
            count <= count + 5'd1;
            if (is_div) opa <= opa << 1;
            else        opb <= opb >> 1;
            if (count == 5'd31) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_exe_mdu.sv
// Self-checking bench for pipe_exe_mdu: transaction-level HI/LO model with
// a per-cycle compare, directed literal cases and randomized traffic.
module tb_pipe_exe_mdu;

  logic        clock = 1'b0;
  logic        reset;
  logic        estart, emthi, emtlo, eflush;
  logic [1:0]  eop;
  logic [31:0] ea, eb;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  pipe_exe_mdu dut (
    .clock (clock),
    .reset (reset),
    .estart(estart),
    .eop   (eop),
    .ea    (ea),
    .eb    (eb),
    .emthi (emthi),
    .emtlo (emtlo),
    .eflush(eflush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Model: cycles left in an accepted operation, a one-cycle completion flag, committed HI/LO.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi, p_lo;
  logic        s_stall, s_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] rh, output logic [31:0] rl);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    rh = 32'd0;
    rl = 32'd0;
    case (op)
      2'd0: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          rl = q[31:0];
          rh = r[31:0];
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model at the edge.
  task automatic tick(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic mh, input logic ml, input logic fl);
    bit idle;
    estart = st; eop = op; ea = a; eb = b; emthi = mh; emtlo = ml; eflush = fl;
    #1;
    idle = (m_left == 0) && !m_done;
    check("stall", 32'(stall), 32'((m_left > 0) || (idle && st && !fl)));
    check("busy",  32'(busy),  32'(!idle));
    check("done",  32'(done),  32'(m_done));
    check("hi",    hi, m_hi);
    check("lo",    lo, m_lo);
    s_stall = stall;
    s_done  = done;
    @(posedge clock);
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (fl) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end
    end else if (st && !fl) begin
      model_result(op, a, b, p_hi, p_lo);
      if (op[1] && b == 32'd0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end else begin
        m_left = 32;
      end
    end else if (!fl) begin
      if (mh) m_hi = a;
      if (ml) m_lo = a;
    end
    @(negedge clock);
  endtask

  // Holds the instruction in execute until its DONE cycle has been seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic mh,
                        output int nstall, output int ndone);
    bit was;
    nstall = 0;
    ndone  = 0;
    for (int i = 0; i < 40; i++) begin
      was = m_done;
      tick(1'b1, op, a, b, mh, 1'b0, 1'b0);
      nstall += int'(s_stall);
      ndone  += int'(s_done);
      if (was) break;
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nd;
    logic [31:0] ra, rb;
    estart = 0; eop = 0; ea = 0; eb = 0; emthi = 0; emtlo = 0; eflush = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clock);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ns, nd);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_stall_cycles", 32'(ns), 32'd33);
    check("multu_done_pulses", 32'(nd), 32'd1);

    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, ns, nd);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, ns, nd);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, ns, nd);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    run_op(2'd3, 32'd100, 32'd0, 1'b0, ns, nd);
    check("div0_hi", hi, 32'd100);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_stall_cycles", 32'(ns), 32'd1);
    check("div0_done_pulses", 32'(nd), 32'd1);

    tick(1'b0, 2'd0, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
    check("mthi", hi, 32'h1234_5678);
    tick(1'b0, 2'd0, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("mtlo", lo, 32'h9ABC_DEF0);
    check("mtlo_keeps_hi", hi, 32'h1234_5678);

    run_op(2'd1, 32'd2, 32'd3, 1'b1, ns, nd);
    check("mthi_vs_start_hi", hi, 32'd0);
    check("mthi_vs_start_lo", lo, 32'd6);

    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 2'd1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
      nd += int'(s_done);
    end
    tick(1'b1, 2'd1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    nd += int'(s_done);
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_no_done", 32'(nd + int'(done)), 32'd0);
    check("flush_hi", hi, 32'd0);
    check("flush_lo", lo, 32'd6);
    run_op(2'd1, 32'd5, 32'd6, 1'b0, ns, nd);
    check("after_flush_lo", lo, 32'd30);
    check("after_flush_stall_cycles", 32'(ns), 32'd33);

    for (int i = 0; i < 15; i++) tick(1'b1, 2'd3, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b0);
    estart = 0; emthi = 0; emtlo = 0; eflush = 0;
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    m_left = 0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    run_op(2'd3, 32'd17, 32'd5, 1'b0, ns, nd);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd2);

    for (int i = 0; i < 3000; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      tick(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), ra, rb,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_exe_mdu.md
# pipe_exe_mdu

Iterative multiply/divide unit for the execute stage of the pipelined CPU. It consumes the operands and operation held in the decode/execute pipeline register (ea, eb and the MDU op decoded alongside ealuc) and computes 64-bit products, or quotient and remainder, into architectural HI/LO registers. While an operation is in flight it drives `stall`, which freezes the PC, the fetch/decode register and the decode/execute register and inserts a bubble into execute/memory. It also services MTHI/MTLO writes and exposes HI/LO to the execute-stage result mux for MFHI/MFLO.

## Interface
Parameters:
- none; data width is fixed at 32 bits and the iteration count at 32.

Ports:
- `clock`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `estart`  in  1  the execute-stage instruction is MULT/MULTU/DIV/DIVU.
- `eop`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `ea`  in  32  rs operand: multiplicand or dividend.
- `eb`  in  32  rt operand: multiplier or divisor.
- `emthi`  in  1  MTHI in execute; writes `ea` into HI.
- `emtlo`  in  1  MTLO in execute; writes `ea` into LO.
- `eflush`  in  1  cancels the execute-stage instruction (branch or exception kill).
- `stall`  out  1  holds the upstream pipeline.
- `busy`  out  1  the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, `estart`=1 and `eflush`=0:**
  - Latch the operation.
  - For signed ops, latch |ea| and |eb| plus the result sign flags: product sign is sa^sb; quotient sign is sa^sb; remainder sign is sa.
  - Clear the 64-bit accumulator and the 5-bit counter, then go to RUN.
- **IDLE, divide with `eb`=0:** go straight to DONE with HI=ea (raw, unmodified) and LO=0xFFFFFFFF, for both DIV and DIVU.
- **RUN, multiply:** shift-add, one multiplier bit per cycle, LSB first.
- **RUN, divide:** restoring shift-subtract, one quotient bit per cycle, MSB first.
- **RUN exit:** the counter increments each cycle. On the cycle with count=31, apply the sign correction (two's-complement negate as required), write HI/LO and go to DONE.
- **Result placement:**
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient (truncated toward zero), HI = remainder (takes the dividend's sign).
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
- **DONE:** `done`=1 for exactly one cycle, then unconditionally go to IDLE. `estart` is ignored in DONE because the same instruction is still in execute.
- **MTHI/MTLO:** honored only in IDLE with `estart`=0 and `eflush`=0. They take effect on the next edge. If `estart` is also set, start wins and the write is dropped.
- **Flush:** `eflush`=1 in IDLE blocks the start. `eflush`=1 in RUN returns to IDLE on the next edge; HI/LO keep their pre-operation values and `done` is not pulsed. `eflush` in DONE has no effect, since HI/LO are already committed.

## Timing
- **Reset values:** state=IDLE, hi=0, lo=0, counter=0, accumulator=0, stall=0, busy=0, done=0. Reset asserted mid-operation aborts it immediately.
- `stall` is combinational: (IDLE & estart & ~eflush) | RUN.
- `busy` = (state != IDLE); `done` = (state == DONE). Both are registered-state decodes.
- **Normal op:** the start cycle is C0. RUN spans C1..C32 and DONE is C33. `stall` is high C0..C32 (33 cycles) and low in C33. HI/LO are new from C33. The instruction leaves execute at the end of C33.
- **Divide by zero:** stall is high only in C0, DONE is C1, and HI/LO are valid in C1.
- A back-to-back MDU instruction arriving in C34 starts normally; there is no dead cycle beyond DONE.
- HI/LO change only on the RUN→DONE edge, the IDLE→DONE edge (divide by zero), or an MTHI/MTLO edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → in C33 hi=0xFFFFFFFE, lo=0x00000001, done=1; stall high for exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 / 0 → stall for 1 cycle, done in C1, hi=100, lo=0xFFFFFFFF.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 → hi/lo updated one edge after each. MTHI asserted together with `estart` → hi reflects only the MDU result.
- MULTU 5 × 6 with `eflush` in C10 → IDLE at C11, stall low, done never pulses, hi/lo unchanged. A second `estart` in C11 is accepted.
- Reset asserted during C15 of a DIVU → busy=0, stall=0, hi=lo=0 immediately (asynchronous). After release, a DIVU 17 / 5 completes with lo=3, hi=2.
